constraint_sampler: RTL and testbench
=====================================

# constraint_sampler

Stimulus-side companion to the generated constraint checkers. Produces pseudo-random candidate assignments on a packed vector that drives a checker's `var_*` inputs. Samples the checker's single `x` result and emits only the satisfying candidates on a valid/ready stream, until a requested count is reached or a try budget runs out. One instance sits in front of each generated checker in the sampling harness.

## Interface

Parameters:
- `VEC_W`, default 64: packed candidate width, equal to the sum of the checker's input widths, with `var_0` in the LSBs.
- `SEED`, default 32'h0000_0001: LFSR value after reset.
- `MAX_TRIES`, default 65535: rejected candidates allowed per run before giving up.
- `CNT_W`, default 16: width of the sample-count and try counters.

Ports:
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begins a run; honoured only in IDLE.
- `num_samples` input CNT_W: satisfying samples requested; latched on `start`.
- `seed_load` input 1: loads `seed` into the LFSR; honoured only in IDLE.
- `seed` input 32: new LFSR value; a value of 0 loads 1 instead.
- `cand` output VEC_W: current candidate, to the checker's inputs.
- `sat` input 1: checker `x`, combinational from `cand`.
- `sample_valid` output 1: a satisfying sample is available.
- `sample_ready` input 1: downstream accepts the sample.
- `sample_data` output VEC_W: the satisfying candidate.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at run end.
- `fail` output 1: sticky; set when the try budget is exhausted, cleared on the next `start`.
- `tries` output CNT_W: rejected candidates in the current run.

## Operation

- The LFSR is a 32-bit Galois LFSR with taps 32'h8020_0003.
  - Next-state rule: next = (s>>1) ^ (s[0] ? TAPS : 0).
  - It advances only in GEN, one step per cycle.
- WORDS = ceil(VEC_W/32).
- Each GEN cycle shifts the word in: `cand` <= {cand, lfsr_next}, truncated to the low VEC_W bits. The last word generated lands in the LSBs.
- FSM states: IDLE, GEN, CHECK, EMIT, DONE.
- IDLE:
  - On `start` with num_samples==0: go to DONE.
  - On `start` otherwise: clear `tries`, the accepted count and `fail`, then go to GEN.
  - `seed_load` and `start` in the same cycle: the seed is loaded first, then the run starts from the new seed.
- GEN: stays for WORDS cycles, then goes to CHECK.
- CHECK:
  - `sat` is registered from the stable `cand`.
  - If sat=1: copy `cand` to `sample_data` and go to EMIT.
  - If sat=0: increment `tries`. If tries reaches MAX_TRIES, set `fail` and go to DONE; otherwise go to GEN.
- EMIT:
  - Hold `sample_valid` high and `sample_data` stable until `sample_ready` is seen.
  - On the handshake: increment the accepted count. If it equals `num_samples`, go to DONE; otherwise go to GEN.
- DONE: pulse `done` for one cycle, then go to IDLE.
- The counters saturate and never wrap.

## Timing

- Reset values:
  - LFSR = SEED.
  - `cand`, `sample_data`, `tries` = 0.
  - `sample_valid`, `busy`, `done`, `fail` = 0.
  - State = IDLE.
- Reset mid-run aborts immediately with the same values; there is no partial `done`.
- Latency from `start` (cycle 0) to the first `sample_valid` is WORDS+2 cycles. Breakdown:
  - GEN in cycles 1..WORDS.
  - CHECK in cycle WORDS+1.
  - EMIT from cycle WORDS+2.
- With `sample_ready` held high, each accepted sample costs WORDS+2 cycles.
- `sample_valid` never drops without a handshake, and `sample_data` never changes while valid.
- `cand` is stable in CHECK and EMIT.
- `start` and `seed_load` outside IDLE are ignored.

## Structure

- A shared package `sampler_pkg` holds:
  - the LFSR taps constant;
  - the state enum;
  - a `lfsr32_next` function.
- One sub-module, `lfsr32`, contains the state register, load/advance enables and zero-seed guard. The FSM, counters and output registers stay in the top level.

## Test plan

- VEC_W=32, reset, sat tied to 1, num_samples=3, ready=1.
  - Required samples: 32'h8020_0003, 32'hC030_0002, 32'h6018_0001.
  - `sample_valid` is first high 3 cycles after `start`.
  - `done` pulses once; `fail` stays 0.
- sat tied to 0, MAX_TRIES=5, num_samples=1.
  - No `sample_valid` ever.
  - `tries` ends at 5, `fail`=1, `done` pulses once.
- sat=1, `sample_ready` held low for 10 cycles.
  - `sample_valid` and `sample_data` stay stable for all 10 cycles.
  - The handshake completes on the first cycle `sample_ready`=1.
- `seed_load` with seed=0 in IDLE, then `start`, num_samples=1, sat=1.
  - The first sample is 32'h8020_0003, because the zero seed is replaced by 1.
- VEC_W=64, sat=1, num_samples=1.
  - `sample_data` = {32'h8020_0003, 32'hC030_0002}.
  - `sample_valid` is first high 4 cycles after `start`.
- Assert `rst` in the middle of EMIT.
  - All outputs return to their reset values asynchronously.
  - A subsequent run reproduces the sequence from the first scenario.

Source files
------------

// File: rtl/sampler_pkg.sv
// Shared definitions for the constraint sampler: LFSR taps, FSM state encoding
// and the Galois LFSR step function.
package sampler_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_CHECK,
    ST_EMIT,
    ST_DONE
  } state_e;

  function automatic logic [31:0] lfsr32_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/constraint_sampler_lfsr32.sv
// 32-bit Galois LFSR with load/advance enables; a zero load value is replaced
// by 1 so the generator can never lock up.
module lfsr32
  import sampler_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] next_c
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  assign next_c = lfsr32_next(state_q);

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
    end else if (advance) begin
      state_d = next_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/constraint_sampler.sv
// Generates pseudo-random candidates for a constraint checker and streams out
// only the satisfying ones until a sample count or a reject budget is reached.
module constraint_sampler
  import sampler_pkg::*;
#(
  parameter int unsigned VEC_W     = 64,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int unsigned MAX_TRIES = 65535,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  output logic [VEC_W-1:0] cand,
  input  logic             sat,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [VEC_W-1:0] sample_data,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] tries
);

  localparam int unsigned WORDS = (VEC_W + 31) / 32;
  localparam int unsigned WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   cand_q, cand_d;
  logic [VEC_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   tries_q, tries_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [WC_W-1:0]    word_q, word_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               lfsr_load;
  logic               lfsr_adv;
  logic [31:0]        lfsr_next_c;
  logic [VEC_W-1:0]   shift_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
  endfunction

  assign lfsr_load = (state_q == ST_IDLE) && seed_load;
  assign lfsr_adv  = (state_q == ST_GEN);

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (seed),
    .advance (lfsr_adv),
    .next_c  (lfsr_next_c)
  );

  // Newest LFSR word enters at the LSBs; older words move up and fall off the top.
  if (VEC_W > 32) begin : g_wide
    assign shift_c = {cand_q[VEC_W-33:0], lfsr_next_c};
  end else begin : g_narrow
    assign shift_c = lfsr_next_c[VEC_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    data_d  = data_q;
    valid_d = valid_q;
    tries_d = tries_q;
    acc_d   = acc_q;
    num_d   = num_q;
    word_d  = word_q;
    fail_d  = fail_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          fail_d = 1'b0;
          if (num_samples == '0) begin
            state_d = ST_DONE;
          end else begin
            tries_d = '0;
            acc_d   = '0;
            num_d   = num_samples;
            word_d  = '0;
            state_d = ST_GEN;
          end
        end
      end
      ST_GEN: begin
        cand_d = shift_c;
        if (word_q == WC_W'(WORDS - 1)) begin
          word_d  = '0;
          state_d = ST_CHECK;
        end else begin
          word_d = word_q + WC_W'(1);
        end
      end
      ST_CHECK: begin
        if (sat) begin
          data_d  = cand_q;
          valid_d = 1'b1;
          state_d = ST_EMIT;
        end else begin
          tries_d = sat_inc(tries_q);
          if (32'(tries_d) >= MAX_TRIES) begin
            fail_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_GEN;
          end
        end
      end
      ST_EMIT: begin
        if (sample_ready) begin
          valid_d = 1'b0;
          acc_d   = sat_inc(acc_q);
          state_d = (acc_d == num_q) ? ST_DONE : ST_GEN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tries_q <= '0;
      acc_q   <= '0;
      num_q   <= '0;
      word_q  <= '0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tries_q <= tries_d;
      acc_q   <= acc_d;
      num_q   <= num_d;
      word_q  <= word_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cand         = cand_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign tries        = tries_q;
  assign fail         = fail_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_constraint_sampler.sv
// Directed bench for constraint_sampler: a 32-bit instance with a 5-reject
// budget and a 64-bit instance, both with the default seed.
module tb_constraint_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_start = 0, a_seed_load = 0, a_sat = 0, a_ready = 0;
  logic [15:0] a_num = 0;
  logic [31:0] a_seed = 0;
  logic [31:0] a_cand, a_data;
  logic        a_valid, a_busy, a_done, a_fail;
  logic [15:0] a_tries;

  logic        b_start = 0, b_seed_load = 0, b_sat = 0, b_ready = 0;
  logic [15:0] b_num = 0;
  logic [31:0] b_seed = 0;
  logic [63:0] b_cand, b_data;
  logic        b_valid, b_busy, b_done, b_fail;
  logic [15:0] b_tries;

  constraint_sampler #(.VEC_W(32), .SEED(32'h1), .MAX_TRIES(5), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .num_samples(a_num),
    .seed_load(a_seed_load), .seed(a_seed), .cand(a_cand), .sat(a_sat),
    .sample_valid(a_valid), .sample_ready(a_ready), .sample_data(a_data),
    .busy(a_busy), .done(a_done), .fail(a_fail), .tries(a_tries)
  );

  constraint_sampler #(.VEC_W(64), .SEED(32'h1), .MAX_TRIES(65535), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .num_samples(b_num),
    .seed_load(b_seed_load), .seed(b_seed), .cand(b_cand), .sat(b_sat),
    .sample_valid(b_valid), .sample_ready(b_ready), .sample_data(b_data),
    .busy(b_busy), .done(b_done), .fail(b_fail), .tries(b_tries)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!a_valid && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!a_valid) begin
      $display("FAIL %s: sample_valid timeout, got %0b want 1", tag, a_valid);
      errors++;
    end
  endtask

  task automatic test_reset();
    a_start = 0; b_start = 0; rst = 1;
    tick(); tick();
    checks++;
    if ({a_cand, a_data, a_tries, a_valid, a_busy, a_done, a_fail} !== '0) begin
      $display("FAIL reset_a: got cand=%h data=%h tries=%0d v=%b b=%b d=%b f=%b want all 0",
               a_cand, a_data, a_tries, a_valid, a_busy, a_done, a_fail);
      errors++;
    end
    checks++;
    if ({b_cand, b_data, b_tries, b_valid, b_busy, b_done, b_fail} !== '0) begin
      $display("FAIL reset_b: got cand=%h data=%h tries=%0d want all 0", b_cand, b_data, b_tries);
      errors++;
    end
    rst = 0;
    tick();
  endtask

  task automatic test_three_samples(input string tag);
    logic [31:0] exp_s [3];
    int first, got, dones;
    exp_s[0] = 32'h8020_0003;
    exp_s[1] = 32'hC030_0002;
    exp_s[2] = 32'h6018_0001;
    a_sat = 1; a_ready = 1; a_num = 3; a_start = 1;
    tick();
    a_start = 0;
    first = 0; got = 0; dones = 0;
    for (int c = 1; c <= 20; c++) begin
      if (a_valid && first == 0) first = c;
      if (a_valid && a_ready) begin
        checks++;
        if (got > 2) begin
          $display("FAIL %s_extra: got sample %h want none", tag, a_data);
          errors++;
        end else if (a_data !== exp_s[got]) begin
          $display("FAIL %s_data%0d: got %h want %h", tag, got, a_data, exp_s[got]);
          errors++;
        end
        got++;
      end
      if (a_done) dones++;
      tick();
    end
    checks++;
    if (first != 3) begin
      $display("FAIL %s_latency: got %0d want 3", tag, first);
      errors++;
    end
    checks++;
    if (got != 3) begin
      $display("FAIL %s_count: got %0d want 3", tag, got);
      errors++;
    end
    checks++;
    if (dones != 1) begin
      $display("FAIL %s_done: got %0d pulses want 1", tag, dones);
      errors++;
    end
    checks++;
    if (a_fail !== 1'b0 || a_busy !== 1'b0) begin
      $display("FAIL %s_end: got fail=%b busy=%b want 0 0", tag, a_fail, a_busy);
      errors++;
    end
  endtask

  task automatic test_reject_budget();
    int valids, dones;
    a_sat = 0; a_ready = 1; a_num = 1; a_start = 1;
    tick();
    a_start = 0;
    valids = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (a_valid) valids++;
      if (a_done) dones++;
      tick();
    end
    checks++;
    if (valids != 0) begin
      $display("FAIL reject_valid: got %0d valid cycles want 0", valids);
      errors++;
    end
    checks++;
    if (a_tries !== 16'd5) begin
      $display("FAIL reject_tries: got %0d want 5", a_tries);
      errors++;
    end
    checks++;
    if (a_fail !== 1'b1) begin
      $display("FAIL reject_fail: got %b want 1", a_fail);
      errors++;
    end
    checks++;
    if (dones != 1) begin
      $display("FAIL reject_done: got %0d pulses want 1", dones);
      errors++;
    end
  endtask

  task automatic test_zero_seed();
    a_seed_load = 1; a_seed = 32'h0;
    tick();
    a_seed_load = 0;
    a_sat = 1; a_ready = 1; a_num = 1; a_start = 1;
    tick();
    a_start = 0;
    checks++;
    if (a_fail !== 1'b0) begin
      $display("FAIL fail_clear: got %b want 0", a_fail);
      errors++;
    end
    wait_a_valid("zero_seed", 10);
    checks++;
    if (a_data !== 32'h8020_0003) begin
      $display("FAIL zero_seed_data: got %h want 80200003", a_data);
      errors++;
    end
    tick(); tick(); tick();
  endtask

  task automatic test_seed_with_start();
    a_seed_load = 1; a_seed = 32'h8020_0003;
    a_sat = 1; a_ready = 1; a_num = 1; a_start = 1;
    tick();
    a_seed_load = 0; a_start = 0;
    wait_a_valid("seed_start", 10);
    checks++;
    if (a_data !== 32'hC030_0002) begin
      $display("FAIL seed_start_data: got %h want c0300002", a_data);
      errors++;
    end
    tick(); tick(); tick();
  endtask

  task automatic test_back_pressure();
    logic [31:0] d0;
    a_sat = 1; a_ready = 0; a_num = 1; a_start = 1;
    tick();
    a_start = 0;
    wait_a_valid("stall", 10);
    d0 = a_data;
    for (int c = 0; c < 10; c++) begin
      a_start = (c == 4);
      a_seed_load = (c == 6);
      a_seed = 32'h1234_5678;
      tick();
      checks++;
      if (a_valid !== 1'b1 || a_data !== d0) begin
        $display("FAIL stall_hold%0d: got v=%b data=%h want 1 %h", c, a_valid, a_data, d0);
        errors++;
      end
    end
    a_start = 0; a_seed_load = 0;
    a_ready = 1;
    tick();
    checks++;
    if (a_valid !== 1'b0 || a_done !== 1'b1) begin
      $display("FAIL stall_handshake: got v=%b done=%b want 0 1", a_valid, a_done);
      errors++;
    end
    tick(); tick();
  endtask

  task automatic test_zero_count();
    a_sat = 1; a_ready = 1; a_num = 0; a_start = 1;
    tick();
    a_start = 0;
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b1 || a_valid !== 1'b0) begin
      $display("FAIL zero_count_done: got d=%b b=%b v=%b want 1 1 0", a_done, a_busy, a_valid);
      errors++;
    end
    tick();
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      $display("FAIL zero_count_idle: got d=%b b=%b want 0 0", a_done, a_busy);
      errors++;
    end
  endtask

  task automatic test_wide();
    int first;
    b_sat = 1; b_ready = 0; b_num = 1; b_start = 1;
    tick();
    b_start = 0;
    first = 0;
    for (int c = 1; c <= 10 && first == 0; c++) begin
      if (b_valid) first = c;
      else tick();
    end
    checks++;
    if (first != 4) begin
      $display("FAIL wide_latency: got %0d want 4", first);
      errors++;
    end
    checks++;
    if (b_data !== {32'h8020_0003, 32'hC030_0002}) begin
      $display("FAIL wide_data: got %h want 80200003c0300002", b_data);
      errors++;
    end
    b_ready = 1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_emit();
    a_sat = 1; a_ready = 0; a_num = 3; a_start = 1;
    tick();
    a_start = 0;
    wait_a_valid("mid_reset", 10);
    #2;
    rst = 1;
    #1;
    checks++;
    if ({a_cand, a_data, a_tries, a_valid, a_busy, a_done, a_fail} !== '0) begin
      $display("FAIL mid_reset: got cand=%h data=%h tries=%0d v=%b b=%b d=%b f=%b want all 0",
               a_cand, a_data, a_tries, a_valid, a_busy, a_done, a_fail);
      errors++;
    end
    tick(); tick();
    rst = 0;
    tick();
    test_three_samples("rerun");
  endtask

  initial begin
    test_reset();
    test_three_samples("basic");
    test_reject_budget();
    test_zero_seed();
    test_seed_with_start();
    test_back_pressure();
    test_zero_count();
    test_wide();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
